// File: rtl/crc_32_pkg.sv
// Shared CRC-32/MPEG-2 constants and the single-byte step function used by
// the PSI/SI table generators.
package crc_32_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    // Folding the whole byte into the top of the register first is equivalent
    // to feeding D[7]..D[0] one bit at a time. The loop unrolls into a flat
    // XOR network, so the full step fits in a single clock.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {d, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ({c[30:0], 1'b0} ^ CRC32_POLY) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_32_step.sv
// Purely combinational CRC-32/MPEG-2 byte step, reusable by any PSI generator.
module crc_32_step
    import crc_32_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  d_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_byte(crc_i, d_i);

endmodule

// File: rtl/crc_32.sv
// Byte-serial CRC-32/MPEG-2 generator: one section byte per enabled clock,
// running CRC presented straight from the register.
module crc_32
    import crc_32_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENA,
    input  logic        INIT,
    input  logic [7:0]  D,
    output logic [31:0] CRC
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_next;

    crc_32_step u_step (
        .crc_i (crc_q),
        .d_i   (D),
        .crc_o (crc_next)
    );

    // INIT outranks ENA, so a byte presented alongside INIT is dropped.
    always_comb begin
        // NOTE: default first, so every path assigns crc_d and no latch is inferred.
        crc_d = crc_q;
        if (INIT) begin
            crc_d = CRC32_INIT;
        end else if (ENA) begin
            crc_d = crc_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: non-blocking assignment for registered state avoids ordering races.
        if (!RST) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign CRC = crc_q;

endmodule

// File: tb/tb_crc_32.sv
// Directed self-checking bench for crc_32: reset, check vector, single bytes,
// gapped enable, section residue, INIT priority and async reset mid-stream.
module tb_crc_32;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        CLK;
    logic        RST;
    logic        ENA;
    logic        INIT;
    logic [7:0]  D;
    logic [31:0] CRC;

    int total;
    int bad;

    logic [7:0]  check_str [9];
    logic [7:0]  pat [12];
    logic [31:0] exp_crc;
    logic [31:0] pat_crc;

    crc_32 dut (
        .CLK  (CLK),
        .RST  (RST),
        .ENA  (ENA),
        .INIT (INIT),
        .D    (D),
        .CRC  (CRC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bit-serial reference: D[7] first, feedback from the register MSB.
    function automatic logic [31:0] ref_byte(input logic [31:0] crc, input logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[31] ^ d[i];
            crc = {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return crc;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive inputs, take one rising edge, return 1 time unit after it.
    task automatic cycle(input logic ena, input logic init, input logic [7:0] d);
        ENA  = ena;
        INIT = init;
        D    = d;
        @(posedge CLK);
        #1;
        ENA  = 1'b0;
        INIT = 1'b0;
        D    = 8'hA5;
    endtask

    initial begin
        int gap;
        total = 0;
        bad   = 0;
        check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        pat = '{8'h00, 8'hB0, 8'h0D, 8'h00, 8'h01, 8'hC1,
                8'h00, 8'h00, 8'h00, 8'h01, 8'hE1, 8'h00};

        // Reset held low across edges, with ENA asserted to show it is ignored.
        RST = 1'b0; ENA = 1'b1; INIT = 1'b0; D = 8'h12;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_held", CRC, 32'hFFFFFFFF);
        ENA = 1'b0;
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 8'h5A);
            check("reset_idle_stable", CRC, 32'hFFFFFFFF);
        end

        // Check vector straight after reset, no INIT needed.
        exp_crc = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, check_str[i]);
            exp_crc = ref_byte(exp_crc, check_str[i]);
            check("check_vec_prefix", CRC, exp_crc);
        end
        check("check_vec_final", CRC, 32'h0376E6E7);
        repeat (3) cycle(1'b0, 1'b0, 8'hFF);
        check("check_vec_hold", CRC, 32'h0376E6E7);

        // Single bytes from init.
        cycle(1'b0, 1'b1, 8'h00);
        check("init_pulse", CRC, 32'hFFFFFFFF);
        cycle(1'b1, 1'b0, 8'h00);
        check("single_00", CRC, 32'h4E08BFB4);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'hFF);
        check("single_ff", CRC, 32'hFFFFFF00);
        check("single_ff_model", CRC, ref_byte(32'hFFFFFFFF, 8'hFF));

        // Gapped enable: random idle cycles between bytes, CRC must hold.
        cycle(1'b0, 1'b1, 8'h00);
        exp_crc = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b0, 8'hC3);
                check("gap_hold", CRC, exp_crc);
            end
            cycle(1'b1, 1'b0, check_str[i]);
            exp_crc = ref_byte(exp_crc, check_str[i]);
        end
        check("gapped_final", CRC, 32'h0376E6E7);

        // PAT section, then its CRC MSB-first: residue must be zero.
        cycle(1'b0, 1'b1, 8'h00);
        pat_crc = 32'hFFFFFFFF;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, pat[i]);
            pat_crc = ref_byte(pat_crc, pat[i]);
        end
        check("pat_crc", CRC, pat_crc);
        cycle(1'b1, 1'b0, pat_crc[31:24]);
        cycle(1'b1, 1'b0, pat_crc[23:16]);
        cycle(1'b1, 1'b0, pat_crc[15:8]);
        cycle(1'b1, 1'b0, pat_crc[7:0]);
        check("pat_residue", CRC, 32'h00000000);

        // INIT together with ENA: byte is lost, register re-initialised.
        cycle(1'b1, 1'b1, 8'h55);
        check("init_over_ena", CRC, 32'hFFFFFFFF);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, check_str[i]);
        check("after_init_check_vec", CRC, 32'h0376E6E7);

        // Asynchronous reset between edges, mid-section.
        cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, check_str[i]);
        check("pre_rst_partial", CRC, ref_byte(ref_byte(ref_byte(32'hFFFFFFFF, 8'h31), 8'h32), 8'h33));
        #1;
        RST = 1'b0;
        #1;
        check("async_rst", CRC, 32'hFFFFFFFF);
        #1;
        RST = 1'b1;
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, check_str[i]);
        check("after_rst_check_vec", CRC, 32'h0376E6E7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
